// File: rtl/tag_alloc_arbiter.sv
// Round-robin arbiter sharing the free-tag FIFO read port, with free-count mirror and flush sequencing.
// Optional consistency checker enabled by defining TAG_ALLOC_CHECK_EN; default build ties o_err to 0.
module tag_alloc_arbiter #(
    parameter int TAG_WIDTH = 6,
    parameter int NUM_REQ   = 4,
    parameter int LOW_WATER = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_req,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [TAG_WIDTH-1:0] o_gnt_tag,
    input  logic                 i_cdb_valid,
    input  logic [TAG_WIDTH-1:0] i_tagout_tf,
    input  logic                 i_ef_tf,
    input  logic                 i_ff_tf,
    output logic                 o_ren_tf,
    input  logic                 i_flush_req,
    output logic                 o_flush_tf,
    output logic                 o_busy,
    output logic [TAG_WIDTH:0]   o_free_cnt,
    output logic                 o_low_tags,
    output logic                 o_err
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam logic [TAG_WIDTH:0] FULL_CNT = {1'b1, {TAG_WIDTH{1'b0}}};
    localparam logic [TAG_WIDTH:0] LOW_CNT  = (TAG_WIDTH+1)'(LOW_WATER);
    localparam logic [PTR_W:0]     NREQ     = (PTR_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [TAG_WIDTH:0] r_free_cnt;
    logic               r_flush_tf;
    logic               r_busy;

    logic [PTR_W:0]     w_idx;
    logic [PTR_W:0]     w_next_sum;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_next_ptr;
    logic               w_found;
    logic               w_grant_en;
    logic [NUM_REQ-1:0] w_gnt;

    // Search upward from the round-robin pointer with wrap; first asserted request wins.
    always_comb begin
        w_idx    = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    // Reset gates the grant so a level request cannot pop the FIFO while it is being reset.
    assign w_grant_en = !reset && (r_state == ST_RUN) && !i_ef_tf && !i_flush_req && w_found;

    always_comb begin
        w_gnt = '0;
        if (w_grant_en) begin
            w_gnt[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_next_sum = {1'b0, w_winner} + {{PTR_W{1'b0}}, 1'b1};
        w_next_ptr = w_next_sum[PTR_W-1:0];
        if (w_next_sum >= NREQ) begin
            w_next_ptr = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_en) begin
            r_rr_ptr <= w_next_ptr;
        end
    end

    // Mirror of the FIFO occupancy; keeps counting returns through flush recovery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_free_cnt <= FULL_CNT;
        end else begin
            case ({i_cdb_valid, w_grant_en})
                2'b10:   r_free_cnt <= r_free_cnt + 1'b1;
                2'b01:   r_free_cnt <= r_free_cnt - 1'b1;
                default: r_free_cnt <= r_free_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_flush_tf <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_flush_req) begin
                        r_state    <= ST_FLUSH;
                        r_flush_tf <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_state    <= ST_DRAIN;
                    r_flush_tf <= 1'b0;
                    r_busy     <= 1'b1;
                end
                ST_DRAIN: begin
                    r_flush_tf <= 1'b0;
                    if (i_ff_tf) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_flush_tf <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef TAG_ALLOC_CHECK_EN
    logic r_err;
    logic w_empty_mismatch;
    logic w_full_mismatch;
    logic w_overfill;

    assign w_empty_mismatch = (r_free_cnt == '0) != i_ef_tf;
    assign w_full_mismatch  = (r_free_cnt == FULL_CNT) != i_ff_tf;
    assign w_overfill       = i_cdb_valid && i_ff_tf && !w_grant_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_empty_mismatch || w_full_mismatch || w_overfill) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_gnt      = w_gnt;
    assign o_gnt_tag  = i_tagout_tf;
    assign o_ren_tf   = w_grant_en;
    assign o_flush_tf = r_flush_tf;
    assign o_busy     = r_busy;
    assign o_free_cnt = r_free_cnt;
    assign o_low_tags = r_free_cnt < LOW_CNT;

endmodule
